vp_recovery_unit: RTL and testbench

//  Recovery side of load value prediction. Opens a speculation window when a

---
 rtl/vp_recovery_unit.sv | 152 +++++++++++++++
 tb/tb_vp_recovery_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vp_recovery_unit.sv
// vp_recovery_unit
// Recovery side of load value prediction. While a predicted load is
// outstanding, every committing register write logs the value it overwrote.
// A misprediction flushes the pipeline, replays the log newest-first into the
// register file, then redirects fetch to the predicted load's PC.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | no prediction outstanding, writebacks not logged
// S_SPEC      | speculation window open, writebacks logged (recover_en=1)
// S_ROLLBACK  | flushing, popping one log entry per cycle to the reg file
// S_REDIRECT  | one-cycle fetch redirect to captured PC, recovery_done=1
module vp_recovery_unit #(
  parameter  int LOG_DEPTH  = 16,
  parameter  int ADDR_WIDTH = 32,
  parameter  int DATA_WIDTH = 32,
  localparam int LOG_PTR    = $clog2(LOG_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  vp_start,
  input  logic [ADDR_WIDTH-1:0] vp_pc,
  input  logic                  vp_correct,
  input  logic                  vp_mispredict,
  input  logic                  wb_valid,
  input  logic [4:0]            wb_reg,
  input  logic [DATA_WIDTH-1:0] wb_old_data,
  output logic                  recover_en,
  output logic                  stall_spec,
  output logic                  flush,
  output logic                  rb_valid,
  output logic [4:0]            rb_reg,
  output logic [DATA_WIDTH-1:0] rb_data,
  output logic                  redirect_valid,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  recovery_done,
  output logic                  err_overflow
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SPEC,
    S_ROLLBACK,
    S_REDIRECT
  } state_t;

  state_t                state_q, state_d;
  logic [LOG_PTR:0]      count_q;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic                  err_q;

  logic [4:0]            log_reg  [LOG_DEPTH];
  logic [DATA_WIDTH-1:0] log_data [LOG_DEPTH];

  logic                  log_full;
  logic                  commit_ok;
  logic                  push;
  logic [LOG_PTR-1:0]    top_idx;

  assign log_full  = (count_q == (LOG_PTR+1)'(LOG_DEPTH));
  // A correct verification closes the window; its same-cycle write is final.
  assign commit_ok = vp_correct && !vp_mispredict;
  assign push      = (state_q == S_SPEC) && wb_valid && !log_full && !commit_ok;
  // When full the low bits wrap to 0, so minus one still lands on the top slot.
  assign top_idx   = count_q[LOG_PTR-1:0] - LOG_PTR'(1);

  // Log storage: push writes the slot just above the current top.
  always_ff @(posedge clk) begin
    if (push) begin
      log_reg[count_q[LOG_PTR-1:0]]  <= wb_reg;
      log_data[count_q[LOG_PTR-1:0]] <= wb_old_data;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Log occupancy, captured load PC and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      pc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (vp_start) begin
            pc_q    <= vp_pc;
            count_q <= '0;
          end
        end
        S_SPEC: begin
          if (wb_valid && log_full) err_q <= 1'b1;
          if (commit_ok)   count_q <= '0;
          else if (push)   count_q <= count_q + 1'b1;
        end
        S_ROLLBACK: begin
          if (count_q != '0) count_q <= count_q - 1'b1;
        end
        default: count_q <= '0;
      endcase
    end
  end

  // Next-state and output decode; rollback data comes straight off the top.
  always_comb begin
    state_d        = state_q;
    recover_en     = 1'b0;
    stall_spec     = 1'b0;
    flush          = 1'b0;
    rb_valid       = 1'b0;
    rb_reg         = '0;
    rb_data        = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    recovery_done  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (vp_start) state_d = S_SPEC;
      end
      S_SPEC: begin
        recover_en = 1'b1;
        stall_spec = log_full;
        if (vp_mispredict)   state_d = S_ROLLBACK;
        else if (vp_correct) state_d = S_IDLE;
      end
      S_ROLLBACK: begin
        flush = 1'b1;
        if (count_q != '0) begin
          rb_valid = 1'b1;
          rb_reg   = log_reg[top_idx];
          rb_data  = log_data[top_idx];
        end
        if (count_q <= (LOG_PTR+1)'(1)) state_d = S_REDIRECT;
      end
      S_REDIRECT: begin
        flush          = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = pc_q;
        recovery_done  = 1'b1;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign err_overflow = err_q;

endmodule

// File: tb/tb_vp_recovery_unit.sv
// Bench for vp_recovery_unit: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level model (log kept as queues,
// recovery expressed as a precomputed schedule of output cycles).
module tb_vp_recovery_unit;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vp_start = 1'b0;
  logic [31:0] vp_pc = '0;
  logic        vp_correct = 1'b0;
  logic        vp_mispredict = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_reg = '0;
  logic [31:0] wb_old_data = '0;
  logic        recover_en, stall_spec, flush, rb_valid;
  logic [4:0]  rb_reg;
  logic [31:0] rb_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        recovery_done, err_overflow;

  vp_recovery_unit #(.LOG_DEPTH(DEPTH), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .vp_start(vp_start), .vp_pc(vp_pc),
    .vp_correct(vp_correct), .vp_mispredict(vp_mispredict),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_old_data(wb_old_data),
    .recover_en(recover_en), .stall_spec(stall_spec), .flush(flush),
    .rb_valid(rb_valid), .rb_reg(rb_reg), .rb_data(rb_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .recovery_done(recovery_done), .err_overflow(err_overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        recover_en;
    logic        stall;
    logic        flush;
    logic        rb_valid;
    logic [4:0]  rb_reg;
    logic [31:0] rb_data;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        done;
  } exp_t;

  int errors = 0;
  int checks = 0;

  // model state
  logic [4:0]  m_reg[$];
  logic [31:0] m_data[$];
  exp_t        recov[$];
  bit          in_window = 0;
  logic [31:0] m_pc = '0;
  bit          m_err = 0;
  exp_t        exp_cur = '0;
  exp_t        exp_nxt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all();
    chk("recover_en",     32'(recover_en),     32'(exp_cur.recover_en));
    chk("stall_spec",     32'(stall_spec),     32'(exp_cur.stall));
    chk("flush",          32'(flush),          32'(exp_cur.flush));
    chk("rb_valid",       32'(rb_valid),       32'(exp_cur.rb_valid));
    chk("rb_reg",         32'(rb_reg),         32'(exp_cur.rb_reg));
    chk("rb_data",        rb_data,             exp_cur.rb_data);
    chk("redirect_valid", 32'(redirect_valid), 32'(exp_cur.redir_valid));
    chk("redirect_pc",    redirect_pc,         exp_cur.redir_pc);
    chk("recovery_done",  32'(recovery_done),  32'(exp_cur.done));
    chk("err_overflow",   32'(err_overflow),   32'(m_err));
  endtask

  function automatic void model_clear();
    m_reg.delete();
    m_data.delete();
  endfunction

  // Advance the model by one clock given this cycle's inputs.
  function automatic void model_step(input bit vs, input logic [31:0] pc, input bit cor,
                                     input bit mis, input bit wv, input logic [4:0] wr,
                                     input logic [31:0] wd);
    exp_t e;
    bit   full;
    if (exp_cur.flush) begin
      // recovering: inputs ignored, play out the schedule
      if (recov.size() > 0) exp_nxt = recov.pop_front();
      else                  exp_nxt = '0;
    end else if (in_window) begin
      full = (m_reg.size() == DEPTH);
      if (wv && full) m_err = 1;
      if (mis) begin
        if (wv && !full) begin m_reg.push_back(wr); m_data.push_back(wd); end
        for (int i = m_reg.size() - 1; i >= 0; i--) begin
          e = '0; e.flush = 1; e.rb_valid = 1; e.rb_reg = m_reg[i]; e.rb_data = m_data[i];
          recov.push_back(e);
        end
        if (m_reg.size() == 0) begin e = '0; e.flush = 1; recov.push_back(e); end
        e = '0; e.flush = 1; e.redir_valid = 1; e.redir_pc = m_pc; e.done = 1;
        recov.push_back(e);
        model_clear();
        in_window = 0;
        exp_nxt = recov.pop_front();
      end else if (cor) begin
        model_clear();
        in_window = 0;
        exp_nxt = '0;
      end else begin
        if (wv && !full) begin m_reg.push_back(wr); m_data.push_back(wd); end
        exp_nxt = '0;
        exp_nxt.recover_en = 1;
        exp_nxt.stall = (m_reg.size() == DEPTH);
      end
    end else begin
      exp_nxt = '0;
      if (vs) begin
        in_window = 1;
        m_pc = pc;
        model_clear();
        exp_nxt.recover_en = 1;
      end
    end
  endfunction

  // Drive one cycle of inputs (called just after a negedge), then check the result.
  task automatic tick(input bit vs = 0, input logic [31:0] pc = 0, input bit cor = 0,
                      input bit mis = 0, input bit wv = 0, input logic [4:0] wr = 0,
                      input logic [31:0] wd = 0);
    vp_start = vs; vp_pc = pc; vp_correct = cor; vp_mispredict = mis;
    wb_valid = wv; wb_reg = wr; wb_old_data = wd;
    model_step(vs, pc, cor, mis, wv, wr, wd);
    @(negedge clk);
    exp_cur = exp_nxt;
    check_all();
  endtask

  task automatic model_reset();
    model_clear();
    recov.delete();
    in_window = 0;
    m_err = 0;
    m_pc = '0;
    exp_cur = '0;
    exp_nxt = '0;
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    tick();

    // 1: correct prediction closes window quietly
    tick(.vs(1), .pc(32'h40));
    chk("t1_recover_en", 32'(recover_en), 32'd1);
    tick(.wv(1), .wr(5'd3), .wd(32'h11));
    tick(.cor(1));
    chk("t1_done", 32'(recovery_done), 32'd0);
    chk("t1_recover_en_off", 32'(recover_en), 32'd0);
    tick();

    // 2: three writes then mispredict
    tick(.vs(1), .pc(32'h80));
    tick(.wv(1), .wr(5'd2), .wd(32'hA));
    tick(.wv(1), .wr(5'd5), .wd(32'hB));
    tick(.wv(1), .wr(5'd2), .wd(32'hC));
    tick(.mis(1));
    chk("t2_rb1_reg", 32'(rb_reg), 32'd2);
    chk("t2_rb1_data", rb_data, 32'hC);
    tick();
    chk("t2_rb2_reg", 32'(rb_reg), 32'd5);
    chk("t2_rb2_data", rb_data, 32'hB);
    tick();
    chk("t2_rb3_reg", 32'(rb_reg), 32'd2);
    chk("t2_rb3_data", rb_data, 32'hA);
    tick();
    chk("t2_redirect", 32'(redirect_valid), 32'd1);
    chk("t2_redirect_pc", redirect_pc, 32'h80);
    chk("t2_done", 32'(recovery_done), 32'd1);
    tick();

    // 3: empty log
    tick(.vs(1), .pc(32'hC0));
    tick(.mis(1));
    chk("t3_empty_flush", 32'(flush), 32'd1);
    chk("t3_empty_rb", 32'(rb_valid), 32'd0);
    tick();
    chk("t3_redirect_pc", redirect_pc, 32'hC0);
    tick();

    // 4: fill the log, overflow, full rollback
    tick(.vs(1), .pc(32'h100));
    for (int i = 0; i < DEPTH; i++) tick(.wv(1), .wr(5'(i)), .wd(32'(i * 3 + 1)));
    chk("t4_stall", 32'(stall_spec), 32'd1);
    chk("t4_err_before", 32'(err_overflow), 32'd0);
    tick(.wv(1), .wr(5'd20), .wd(32'hDEAD));
    chk("t4_err", 32'(err_overflow), 32'd1);
    tick(.mis(1));
    chk("t4_rb_first_reg", 32'(rb_reg), 32'd15);
    chk("t4_rb_first_data", rb_data, 32'd46);
    for (int i = 0; i < DEPTH - 1; i++) tick();
    chk("t4_rb_last_data", rb_data, 32'd1);
    tick();
    chk("t4_redirect", 32'(redirect_valid), 32'd1);
    tick();

    // 5: correct + mispredict + write in one cycle
    tick(.vs(1), .pc(32'h140));
    tick(.cor(1), .mis(1), .wv(1), .wr(5'd7), .wd(32'h5));
    chk("t5_rb_reg", 32'(rb_reg), 32'd7);
    chk("t5_rb_data", rb_data, 32'h5);
    tick();
    chk("t5_redirect", 32'(redirect_valid), 32'd1);
    tick();

    // 6: reset during rollback
    tick(.vs(1), .pc(32'h180));
    tick(.wv(1), .wr(5'd1), .wd(32'h21));
    tick(.wv(1), .wr(5'd4), .wd(32'h22));
    tick(.mis(1));
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("t6_flush_rst", 32'(flush), 32'd0);
    chk("t6_rb_rst", 32'(rb_valid), 32'd0);
    chk("t6_err_rst", 32'(err_overflow), 32'd0);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
    tick();
    tick();
    tick(.vs(1), .pc(32'h1C0));
    tick(.wv(1), .wr(5'd9), .wd(32'h33));
    tick(.mis(1));
    chk("t6_after_rb", rb_data, 32'h33);
    tick();
    chk("t6_after_redirect_pc", redirect_pc, 32'h1C0);
    tick();

    // random traffic
    for (int n = 0; n < 600; n++) begin
      bit          vs, cor, mis, wv;
      logic [31:0] pc, wd;
      logic [4:0]  wr;
      vs  = ($urandom_range(0, 9) == 0);
      cor = ($urandom_range(0, 24) == 0);
      mis = ($urandom_range(0, 19) == 0);
      wv  = ($urandom_range(0, 9) < 6);
      pc  = $urandom();
      wr  = 5'($urandom_range(0, 31));
      wd  = $urandom();
      tick(vs, pc, cor, mis, wv, wr, wd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
